// File: rtl/udp_rx_parser.sv
// GMII receive-side UDP parser: strips preamble/SFD, filters Ethernet/IPv4/UDP headers,
// checks the FCS and forwards UDP payload bytes with per-frame status pulses.
module udp_rx_parser #(
    parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80A0A,
    parameter logic [15:0] LOCAL_PORT = 16'd1234
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    output logic        payload_valid,
    output logic [7:0]  payload_data,
    output logic        payload_last,
    output logic [15:0] payload_len,
    output logic [31:0] src_ip,
    output logic [15:0] src_port,
    output logic        frame_done,
    output logic        frame_err,
    output logic        frame_drop
);

    typedef enum logic [3:0] {
        StWaitIdle, StIdle, StPreamble, StEthHdr, StIpHdr, StUdpHdr, StPayload, StTrail, StDrop
    } state_t;

    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_pre_cnt;
    logic [47:0] r_sh;
    logic [31:0] r_crc;
    logic        r_err_seen;
    logic [15:0] r_remain;
    logic [31:0] r_ip_tmp;
    logic [15:0] r_sport_tmp;
    logic [15:0] r_ulen;
    logic        r_payload_valid;
    logic [7:0]  r_payload_data;
    logic        r_payload_last;
    logic [15:0] r_payload_len;
    logic [31:0] r_src_ip;
    logic [15:0] r_src_port;
    logic        r_frame_done;
    logic        r_frame_err;
    logic        r_frame_drop;

    logic [47:0] w_sh_next;
    logic [31:0] w_crc_next;

    // Header fields are compared on their last byte using the shifted-in view.
    assign w_sh_next  = {r_sh[39:0], gmii_rxd};
    assign w_crc_next = crc32_byte(r_crc, gmii_rxd);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state         <= StWaitIdle;
            r_cnt           <= 16'd0;
            r_pre_cnt       <= 3'd0;
            r_sh            <= 48'd0;
            r_crc           <= 32'hFFFFFFFF;
            r_err_seen      <= 1'b0;
            r_remain        <= 16'd0;
            r_ip_tmp        <= 32'd0;
            r_sport_tmp     <= 16'd0;
            r_ulen          <= 16'd0;
            r_payload_valid <= 1'b0;
            r_payload_data  <= 8'd0;
            r_payload_last  <= 1'b0;
            r_payload_len   <= 16'd0;
            r_src_ip        <= 32'd0;
            r_src_port      <= 16'd0;
            r_frame_done    <= 1'b0;
            r_frame_err     <= 1'b0;
            r_frame_drop    <= 1'b0;
        end else begin
            r_payload_valid <= 1'b0;
            r_payload_last  <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_err     <= 1'b0;
            r_frame_drop    <= 1'b0;
            if (gmii_rx_dv) begin
                r_sh  <= w_sh_next;
                r_crc <= w_crc_next;
            end

            case (r_state)
                StWaitIdle: begin
                    if (!gmii_rx_dv) r_state <= StIdle;
                end
                StIdle: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == 8'h55) begin
                            r_pre_cnt <= 3'd1;
                            r_state   <= StPreamble;
                        end else begin
                            r_state <= StDrop;
                        end
                    end
                end
                StPreamble: begin
                    if (!gmii_rx_dv) begin
                        r_frame_drop <= 1'b1;
                        r_state      <= StIdle;
                    end else if (gmii_rxd == 8'hD5) begin
                        r_crc      <= 32'hFFFFFFFF;
                        r_cnt      <= 16'd0;
                        r_err_seen <= 1'b0;
                        r_state    <= StEthHdr;
                    end else if (gmii_rxd == 8'h55 && r_pre_cnt != 3'd7) begin
                        r_pre_cnt <= r_pre_cnt + 3'd1;
                    end else begin
                        r_state <= StDrop;
                    end
                end
                StEthHdr, StIpHdr, StUdpHdr: begin
                    if (!gmii_rx_dv) begin
                        r_frame_drop <= 1'b1;
                        r_state      <= StIdle;
                    end else if (gmii_rx_er) begin
                        r_state <= StDrop;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                        if (r_state == StEthHdr) begin
                            if (r_cnt == 16'd5 && w_sh_next != LOCAL_MAC && w_sh_next != '1) begin
                                r_state <= StDrop;
                            end
                            if (r_cnt == 16'd13) begin
                                r_cnt   <= 16'd0;
                                r_state <= (w_sh_next[15:0] == 16'h0800) ? StIpHdr : StDrop;
                            end
                        end else if (r_state == StIpHdr) begin
                            if ((r_cnt == 16'd0 && gmii_rxd != 8'h45) ||
                                (r_cnt == 16'd9 && gmii_rxd != 8'h11)) begin
                                r_state <= StDrop;
                            end
                            if (r_cnt == 16'd15) r_ip_tmp <= w_sh_next[31:0];
                            if (r_cnt == 16'd19) begin
                                r_cnt   <= 16'd0;
                                r_state <= (w_sh_next[31:0] == LOCAL_IP) ? StUdpHdr : StDrop;
                            end
                        end else begin
                            if (r_cnt == 16'd1) r_sport_tmp <= w_sh_next[15:0];
                            if (r_cnt == 16'd3 && w_sh_next[15:0] != LOCAL_PORT) r_state <= StDrop;
                            if (r_cnt == 16'd5) begin
                                r_ulen <= w_sh_next[15:0];
                                if (w_sh_next[15:0] < 16'd8) r_state <= StDrop;
                            end
                            if (r_cnt == 16'd7) begin
                                r_src_ip      <= r_ip_tmp;
                                r_src_port    <= r_sport_tmp;
                                r_payload_len <= r_ulen - 16'd8;
                                r_remain      <= r_ulen - 16'd8;
                                r_state       <= (r_ulen == 16'd8) ? StTrail : StPayload;
                            end
                        end
                    end
                end
                StPayload: begin
                    if (!gmii_rx_dv) begin
                        // Truncated payload: report as bad, never flag last.
                        r_frame_done <= 1'b1;
                        r_frame_err  <= 1'b1;
                        r_state      <= StIdle;
                    end else begin
                        if (gmii_rx_er) r_err_seen <= 1'b1;
                        r_payload_valid <= 1'b1;
                        r_payload_data  <= gmii_rxd;
                        r_remain        <= r_remain - 16'd1;
                        if (r_remain == 16'd1) begin
                            r_payload_last <= 1'b1;
                            r_state        <= StTrail;
                        end
                    end
                end
                StTrail: begin
                    if (!gmii_rx_dv) begin
                        r_frame_done <= 1'b1;
                        r_frame_err  <= r_err_seen | (r_crc != CrcResidue);
                        r_state      <= StIdle;
                    end else if (gmii_rx_er) begin
                        r_err_seen <= 1'b1;
                    end
                end
                StDrop: begin
                    if (!gmii_rx_dv) begin
                        r_frame_drop <= 1'b1;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StWaitIdle;
            endcase
        end
    end

    assign payload_valid = r_payload_valid;
    assign payload_data  = r_payload_data;
    assign payload_last  = r_payload_last;
    assign payload_len   = r_payload_len;
    assign src_ip        = r_src_ip;
    assign src_port      = r_src_port;
    assign frame_done    = r_frame_done;
    assign frame_err     = r_frame_err;
    assign frame_drop    = r_frame_drop;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Randomized scoreboard bench for udp_rx_parser: a frame-level reference model pushes the
// expected output events, and a negedge monitor pops and compares them.
module tb_udp_rx_parser;

    localparam logic [47:0] LMac   = 48'h000A3501FEC0;
    localparam logic [47:0] BMac   = 48'hFFFFFFFFFFFF;
    localparam logic [31:0] LIp    = 32'hC0A80A0A;
    localparam logic [15:0] LPort  = 16'd1234;

    logic        sys_clk    = 1'b0;
    logic        sys_rst    = 1'b1;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  gmii_rxd   = 8'd0;
    logic        payload_valid;
    logic [7:0]  payload_data;
    logic        payload_last;
    logic [15:0] payload_len;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic        frame_done;
    logic        frame_err;
    logic        frame_drop;

    udp_rx_parser #(
        .LOCAL_MAC (LMac),
        .LOCAL_IP  (LIp),
        .LOCAL_PORT(LPort)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rx_er   (gmii_rx_er),
        .gmii_rxd     (gmii_rxd),
        .payload_valid(payload_valid),
        .payload_data (payload_data),
        .payload_last (payload_last),
        .payload_len  (payload_len),
        .src_ip       (src_ip),
        .src_port     (src_port),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .frame_drop   (frame_drop)
    );

    always #4 sys_clk = ~sys_clk;

    // kind: 0 payload byte, 1 frame_done, 2 frame_drop
    typedef struct {
        int          kind;
        logic [7:0]  data;
        logic        last;
        logic        err;
        logic [15:0] len;
        logic [31:0] sip;
        logic [15:0] sport;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] fr[$];
    logic [7:0] pl[$];
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Standard Ethernet CRC-32 (with final inversion) over the first n bytes of fr.
    function automatic logic [31:0] crc32_ref(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ fr[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic push_n(input logic [47:0] v, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) fr.push_back(v[8*i +: 8]);
    endtask

    task automatic fill_seq(input int n, input logic [7:0] start);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(start + 8'(i));
    endtask

    task automatic fill_rand(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    task automatic build(input logic [47:0] mac, input logic [15:0] et, input logic [7:0] vihl,
                         input logic [7:0] proto, input logic [31:0] dip, input logic [15:0] sport,
                         input logic [15:0] dport, input int ulen, input int pad, input bit bad_fcs);
        logic [15:0] u;
        logic [31:0] fcs;
        u = (ulen < 0) ? 16'(8 + pl.size()) : 16'(ulen);
        fr.delete();
        push_n(mac, 6);
        push_n(48'h020000000001, 6);
        push_n({32'd0, et}, 2);
        push_n({40'd0, vihl}, 1);
        push_n(48'd0, 1);
        push_n({32'd0, u + 16'd20}, 2);
        push_n(48'h0000_4000_4000, 5);
        push_n({40'd0, proto}, 1);
        push_n(48'd0, 2);
        push_n({16'd0, 32'($urandom)}, 4);
        push_n({16'd0, dip}, 4);
        push_n({32'd0, sport}, 2);
        push_n({32'd0, dport}, 2);
        push_n({32'd0, u}, 2);
        push_n(48'd0, 2);
        foreach (pl[i]) fr.push_back(pl[i]);
        for (int i = 0; i < pad; i++) fr.push_back(8'($urandom));
        fcs = crc32_ref(fr.size());
        if (bad_fcs) fcs[5] = ~fcs[5];
        push_n({16'd0, fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24]}, 4);
    endtask

    task automatic build_good(input logic [15:0] sport, input int pad);
        build(LMac, 16'h0800, 8'h45, 8'h11, LIp, sport, LPort, -1, pad, 1'b0);
    endtask

    // Expected outputs for the first n bytes after SFD; aborted frames report no status pulse.
    task automatic model(input int n, input int pre_n, input int er_pos, input bit aborted);
        ev_t         e;
        logic [47:0] mac;
        logic [15:0] ulen;
        logic [31:0] fcs;
        bit          ok;
        int          plen;
        int          avail;
        e.kind = 0; e.data = 8'd0; e.last = 1'b0; e.err = 1'b0;
        e.len = 16'd0; e.sip = 32'd0; e.sport = 16'd0;
        ulen = 16'd0;
        ok = (pre_n >= 1 && pre_n <= 7 && n >= 42 && !(er_pos >= 0 && er_pos < 42));
        if (ok) begin
            mac  = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
            ulen = {fr[38], fr[39]};
            ok = (mac == LMac || mac == BMac) && {fr[12], fr[13]} == 16'h0800 &&
                 fr[14] == 8'h45 && fr[23] == 8'h11 &&
                 {fr[30], fr[31], fr[32], fr[33]} == LIp &&
                 {fr[36], fr[37]} == LPort && ulen >= 16'd8;
        end
        if (!ok) begin
            if (!aborted) begin
                e.kind = 2;
                exp_q.push_back(e);
            end
            return;
        end
        plen  = int'(ulen) - 8;
        avail = n - 42;
        for (int i = 0; i < plen && i < avail; i++) begin
            e.kind = 0;
            e.data = fr[42 + i];
            e.last = (i == plen - 1);
            exp_q.push_back(e);
        end
        if (aborted) return;
        e.kind  = 1;
        e.data  = 8'd0;
        e.last  = 1'b0;
        e.len   = 16'(plen);
        e.sip   = {fr[26], fr[27], fr[28], fr[29]};
        e.sport = {fr[34], fr[35]};
        if (avail < plen) begin
            e.err = 1'b1;
        end else if (er_pos >= 42 && er_pos < n) begin
            e.err = 1'b1;
        end else begin
            fcs   = {fr[n - 1], fr[n - 2], fr[n - 3], fr[n - 4]};
            e.err = (crc32_ref(n - 4) != fcs);
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic d, input logic er, input logic [7:0] b, input logic r);
        @(posedge sys_clk);
        #1;
        gmii_rx_dv = d;
        gmii_rx_er = er;
        gmii_rxd   = b;
        sys_rst    = r;
    endtask

    task automatic check_reset_outputs();
        check("rst_ctl", 64'({payload_valid, payload_data, payload_last, frame_done, frame_err,
                              frame_drop}), 64'd0);
        check("rst_fields", {payload_len, src_ip, src_port}, 64'd0);
    endtask

    task automatic run(input int nsend, input int pre_n, input int er_pos, input int rst_at,
                       input int gap);
        model((rst_at >= 0) ? rst_at : nsend, pre_n, er_pos, rst_at >= 0);
        for (int i = 0; i < pre_n; i++) drive(1'b1, 1'b0, 8'h55, 1'b0);
        drive(1'b1, 1'b0, 8'hD5, 1'b0);
        for (int i = 0; i < nsend; i++) begin
            drive(1'b1, 1'(i == er_pos), fr[i], 1'(i == rst_at));
            if (rst_at >= 0 && i == rst_at + 1) begin
                @(negedge sys_clk);
                check_reset_outputs();
            end
        end
        for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    always @(negedge sys_clk) begin : monitor
        ev_t e;
        int  kind;
        if (payload_valid === 1'b1 || frame_done === 1'b1 || frame_drop === 1'b1) begin
            kind = payload_valid ? 0 : (frame_done ? 1 : 2);
            check("done_drop_exclusive", 64'(frame_done & frame_drop), 64'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: kind %0d with nothing expected at %0t",
                         kind, $time);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", 64'(kind), 64'(e.kind));
                if (kind == e.kind && kind == 0) begin
                    check("payload_data", 64'(payload_data), 64'(e.data));
                    check("payload_last", 64'(payload_last), 64'(e.last));
                end else if (kind == e.kind && kind == 1) begin
                    check("frame_err", 64'(frame_err), 64'(e.err));
                    check("payload_len", 64'(payload_len), 64'(e.len));
                    check("src_ip", 64'(src_ip), 64'(e.sip));
                    check("src_port", 64'(src_port), 64'(e.sport));
                end
            end
        end
    end

    initial begin
        int sel;
        int plen;
        int pad;
        int gap;
        int nsend;
        int erp;
        logic [15:0] sp;

        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge sys_clk);
        check_reset_outputs();
        repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);

        // Good frame, payload 01..08, then the same with a corrupted FCS.
        fill_seq(8, 8'h01);
        build_good(16'd5000, 10);
        run(fr.size(), 7, -1, -1, 3);
        build(LMac, 16'h0800, 8'h45, 8'h11, LIp, 16'd5000, LPort, -1, 10, 1'b1);
        run(fr.size(), 7, -1, -1, 3);

        // Frames aimed elsewhere.
        build(LMac, 16'h0800, 8'h45, 8'h11, 32'hC0A80A0B, 16'd5000, LPort, -1, 10, 1'b0);
        run(fr.size(), 7, -1, -1, 3);
        build(LMac, 16'h0800, 8'h45, 8'h11, LIp, 16'd5000, 16'd1235, -1, 10, 1'b0);
        run(fr.size(), 7, -1, -1, 3);
        build(LMac, 16'h0806, 8'h45, 8'h11, LIp, 16'd5000, LPort, -1, 10, 1'b0);
        run(fr.size(), 7, -1, -1, 3);
        build(48'h000A3501FEC1, 16'h0800, 8'h45, 8'h11, LIp, 16'd5000, LPort, -1, 10, 1'b0);
        run(fr.size(), 7, -1, -1, 3);
        build(LMac, 16'h0800, 8'h46, 8'h11, LIp, 16'd5000, LPort, -1, 10, 1'b0);
        run(fr.size(), 7, -1, -1, 3);
        build(LMac, 16'h0800, 8'h45, 8'h06, LIp, 16'd5000, LPort, -1, 10, 1'b0);
        run(fr.size(), 7, -1, -1, 3);
        pl.delete();
        build(LMac, 16'h0800, 8'h45, 8'h11, LIp, 16'd5000, LPort, 7, 18, 1'b0);
        run(fr.size(), 7, -1, -1, 3);

        // Broadcast, 2-byte payload followed by padding.
        pl.delete();
        pl.push_back(8'hAA);
        pl.push_back(8'hBB);
        build(BMac, 16'h0800, 8'h45, 8'h11, LIp, 16'd6000, LPort, -1, 44, 1'b0);
        run(fr.size(), 7, -1, -1, 3);

        // Back-to-back frames with a single idle cycle.
        fill_rand(20);
        build_good(16'd7000, 0);
        run(fr.size(), 7, -1, -1, 1);
        fill_rand(5);
        build_good(16'd7001, 13);
        run(fr.size(), 7, -1, -1, 3);

        // Reset in the middle of a payload, then a fresh frame.
        fill_rand(30);
        build_good(16'd8000, 0);
        run(fr.size(), 7, -1, 52, 3);
        fill_rand(12);
        build_good(16'd8001, 6);
        run(fr.size(), 7, -1, -1, 3);

        // Error strobes, truncation, preamble limits, empty payload.
        fill_rand(10);
        build_good(16'd9000, 8);
        run(fr.size(), 7, 45, -1, 3);
        run(fr.size(), 7, 20, -1, 3);
        run(45, 7, -1, -1, 3);
        run(fr.size(), 8, -1, -1, 3);
        run(fr.size(), 1, -1, -1, 3);
        run(30, 7, -1, -1, 3);
        pl.delete();
        build_good(16'd9001, 18);
        run(fr.size(), 7, -1, -1, 3);

        for (int k = 0; k < 40; k++) begin
            sel  = int'($urandom_range(0, 11));
            plen = int'($urandom_range(0, 40));
            pad  = int'($urandom_range(0, 20));
            gap  = int'($urandom_range(1, 4));
            sp   = 16'($urandom);
            erp  = -1;
            fill_rand(plen);
            case (sel)
                6: build(LMac, 16'h0800, 8'h45, 8'h11, LIp, sp, LPort, -1, pad, 1'b1);
                7: build(LMac, 16'h0800, 8'h45, 8'h11, LIp ^ 32'h1, sp, LPort, -1, pad, 1'b0);
                8: build(LMac, 16'h0800, 8'h45, 8'h11, LIp, sp, LPort + 16'd1, -1, pad, 1'b0);
                9: build(BMac, 16'h0800, 8'h45, 8'h11, LIp, sp, LPort, -1, pad, 1'b0);
                default: build_good(sp, pad);
            endcase
            nsend = fr.size();
            if (sel == 10 && plen > 0) erp = 42 + int'($urandom_range(0, plen - 1));
            if (sel == 11 && plen > 0) nsend = 42 + int'($urandom_range(0, plen - 1));
            run(nsend, int'($urandom_range(1, 7)), erp, -1, gap);
        end

        repeat (20) drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_rx_parser.md
Name: udp_rx_parser

Overview:
- Receive-side counterpart of the board's UDP transmit path.
- Consumes the GMII byte stream from the SGMII/PCS receiver (125 MHz, one byte per cycle) and strips preamble/SFD.
- Filters on Ethernet, IPv4 and UDP headers, checks the FCS, and delivers UDP payload bytes with per-frame status to user logic.
- Used in loopback (txp→rxp) simulation and on hardware.

Parameters:
LOCAL_MAC, 48'h000A3501FEC0, accepted destination MAC (broadcast FF:FF:FF:FF:FF:FF also accepted)
LOCAL_IP, 32'hC0A80A0A, accepted IPv4 destination (192.168.10.10)
LOCAL_PORT, 16'd1234, accepted UDP destination port

Ports:
sys_clk  in  1  125 MHz GMII receive clock; single clock domain
sys_rst  in  1  synchronous, active-high reset
gmii_rx_dv  in  1  receive data valid
gmii_rx_er  in  1  receive error
gmii_rxd  in  8  receive byte
payload_valid  out  1  payload byte valid
payload_data  out  8  payload byte
payload_last  out  1  with final payload byte (per UDP length)
payload_len  out  16  UDP length − 8
src_ip  out  32  IPv4 source address of current frame
src_port  out  16  UDP source port of current frame
frame_done  out  1  one-cycle pulse, end of an accepted frame
frame_err  out  1  qualifies frame_done: frame bad
frame_drop  out  1  one-cycle pulse, frame filtered or malformed

Behaviour:
- All outputs reset to 0. After reset, state WAIT_IDLE. Reset mid-frame: the remainder of that frame is ignored; no pulses for it.
- States:
  - WAIT_IDLE: go to IDLE when gmii_rx_dv=0.
  - IDLE: on dv=1 go to PREAMBLE.
  - PREAMBLE: accept 0x55 bytes (1–7); 0xD5 → ETH_HDR. Any other byte, or >7 × 0x55 → DROP.
  - ETH_HDR (14 bytes):
    - dst MAC must equal LOCAL_MAC or broadcast.
    - EtherType bytes 12–13 must be 0x0800.
  - IP_HDR (20 bytes):
    - byte0 must be 0x45 and byte9 must be 0x11; dst IP (bytes 16–19) must equal LOCAL_IP.
    - src IP is captured from bytes 12–15.
    - IP checksum is not checked. Options (IHL≠5) → DROP.
  - UDP_HDR (8 bytes):
    - capture src port.
    - dst port must equal LOCAL_PORT.
    - capture UDP length; length <8 → DROP.
    - payload_len, src_ip and src_port are updated at the end of UDP_HDR and held until the next accepted frame's UDP_HDR.
  - PAYLOAD: forward payload_len bytes. Length 0 skips directly to TRAIL.
  - TRAIL: consume padding and FCS until dv=0.
  - DROP: consume until dv=0, then pulse frame_drop; → IDLE.
  - Any filter mismatch → DROP.
- Latency: payload_data / payload_valid are registered, one cycle after the byte appears on gmii_rxd. payload_last is set on the byte where the remaining count reaches 0.
- Padding (payload < 18 bytes) is never forwarded.
- CRC-32:
  - reflected polynomial 0xEDB88320, register initialised to 0xFFFFFFFF at SFD.
  - updated on every byte after SFD, including the 4 FCS bytes.
  - frame good iff register == 0xDEBB20E3 when dv falls.
- Frame end (dv 1→0) in PAYLOAD or TRAIL:
  - frame_done pulses the cycle after dv falls.
  - frame_err=1 if CRC bad, or gmii_rx_er was seen anytime after SFD, or the payload was truncated (dv fell before payload_last).
  - On truncation payload_last is never asserted.
- dv falling in ETH/IP/UDP_HDR or PREAMBLE → frame_drop pulse, no frame_done.
- gmii_rx_er during headers → DROP.
- Frames separated by a single dv=0 cycle must both be received: the end-of-frame cycle must double as IDLE so the next preamble is seen.
- frame_done and frame_drop are never asserted together. Counters: byte counter 16 bits, saturating is not needed (frames ≤1518 bytes).

Test Plan:
- Good frame, LOCAL_MAC/IP/port, UDP length 16, payload 0x01..0x08, valid FCS → 8 payload_valid cycles, data 0x01..0x08, payload_last on 0x08, payload_len=8, frame_done=1 with frame_err=0.
- Same frame, one FCS bit flipped → identical payload stream, frame_done=1 with frame_err=1.
- Frames aimed elsewhere, each → no payload_valid, one frame_drop pulse per frame:
  - dst IP 192.168.10.11
  - dst port 1235
  - EtherType 0x0806
- Broadcast MAC, UDP length 10 (2-byte payload 0xAA,0xBB), 44 padding bytes, valid FCS → exactly 2 payload bytes, no pad bytes forwarded, frame_done good.
- Two good frames with a 1-cycle dv gap → both delivered; src_port updated between them; two frame_done pulses.
- sys_rst asserted for 1 cycle mid-payload, then a fresh good frame → all outputs 0 during reset, no pulses for the aborted frame, second frame received correctly.
